pc_gen: RTL and testbench

- Parametrised program-counter generator; next generation of the fetch-stage PC register.
- Holds the fetch PC and selects the next PC from a priority-ordered set of sources: trap, EX branch, ID jump, sequential increment.
- Adds a valid/ready handshake to fetch, a hazard stall, and a redirect that is latched when it arrives during a stall and applied later.
- Sits between hazard unit / EX / ID redirect logic and instruction memory.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_redirect_arb.sv | 50 +++++
 rtl/pc_gen.sv | 160 ++++++++++++++++
 tb/tb_pc_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the pc_gen program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    // Encodings ascend with priority so sources compare numerically.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ID   = 2'd1,
        SRC_EX   = 2'd2,
        SRC_TRAP = 2'd3
    } pc_src_e;

    // Ties resolve to the first argument, so a fresh request beats an equal pending one.
    function automatic pc_src_e src_max(input pc_src_e a, input pc_src_e b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority select over trap, EX, ID and a pending redirect,
// returning the winning source, raw and aligned targets, and a misalign flag.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 4
) (
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_tgt_i,
    input  logic            ex_i,
    input  logic [XLEN-1:0] ex_tgt_i,
    input  logic            id_i,
    input  logic [XLEN-1:0] id_tgt_i,
    input  pc_src_e         pend_src_i,
    input  logic [XLEN-1:0] pend_tgt_i,
    output logic            valid_o,
    output pc_src_e         src_o,
    output logic [XLEN-1:0] raw_o,
    output logic [XLEN-1:0] tgt_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);

    pc_src_e         fresh_src;
    logic [XLEN-1:0] fresh_tgt;

    always_comb begin
        fresh_src = SRC_NONE;
        fresh_tgt = '0;
        if (trap_i) begin
            fresh_src = SRC_TRAP;
            fresh_tgt = trap_tgt_i;
        end else if (ex_i) begin
            fresh_src = SRC_EX;
            fresh_tgt = ex_tgt_i;
        end else if (id_i) begin
            fresh_src = SRC_ID;
            fresh_tgt = id_tgt_i;
        end

        src_o      = src_max(fresh_src, pend_src_i);
        raw_o      = (src_o == fresh_src) ? fresh_tgt : pend_tgt_i;
        tgt_o      = raw_o & ~LOW_MASK;
        misalign_o = |(raw_o & LOW_MASK);
        valid_o    = (src_o != SRC_NONE);
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with prioritised redirects, stall-time
// pending redirect and fetch handshake. Optional redirect trace: PC_TRACE_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     STEP         = 4,
    parameter int unsigned     TRACE_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           trap_valid,
    input  logic [XLEN-1:0]                trap_target,
    input  logic                           ex_redirect,
    input  logic [XLEN-1:0]                ex_target,
    input  logic                           id_redirect,
    input  logic [XLEN-1:0]                id_target,
    input  logic                           pc_ready,
    output logic [XLEN-1:0]                pc,
    output logic                           pc_valid,
    output logic                           redirected,
    output logic                           misalign_err
`ifdef PC_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN+1:0]                trace_entry,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
`endif
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            red_q, red_d;
    logic            mis_q, mis_d;
    pc_src_e         pend_src_q, pend_src_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            apply;

    logic            arb_valid;
    pc_src_e         arb_src;
    logic [XLEN-1:0] arb_raw;
    logic [XLEN-1:0] arb_tgt;
    logic            arb_mis;

    pc_redirect_arb #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_arb (
        .trap_i     (trap_valid),
        .trap_tgt_i (trap_target),
        .ex_i       (ex_redirect),
        .ex_tgt_i   (ex_target),
        .id_i       (id_redirect),
        .id_tgt_i   (id_target),
        .pend_src_i (pend_src_q),
        .pend_tgt_i (pend_tgt_q),
        .valid_o    (arb_valid),
        .src_o      (arb_src),
        .raw_o      (arb_raw),
        .tgt_o      (arb_tgt),
        .misalign_o (arb_mis)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        red_d      = 1'b0;
        mis_d      = 1'b0;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        apply      = 1'b0;

        case (state_q)
            BOOT: begin
                valid_d = 1'b1;
                state_d = RUN;
            end
            default: begin
                // RUN and PEND share one path: pend_src_q is SRC_NONE outside PEND.
                if (arb_src == SRC_TRAP || (arb_valid && !stall)) begin
                    apply = 1'b1;
                end else if (arb_valid) begin
                    pend_src_d = arb_src;
                    pend_tgt_d = arb_raw;
                    state_d    = PEND;
                end else if (!stall && valid_q && pc_ready) begin
                    pc_d = pc_q + XLEN'(STEP);
                end
            end
        endcase

        if (apply) begin
            pc_d       = arb_tgt;
            red_d      = 1'b1;
            mis_d      = arb_mis;
            pend_src_d = SRC_NONE;
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            red_q      <= 1'b0;
            mis_q      <= 1'b0;
            pend_src_q <= SRC_NONE;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            red_q      <= red_d;
            mis_q      <= mis_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = valid_q;
    assign redirected   = red_q;
    assign misalign_err = mis_q;

`ifdef PC_TRACE_EN
    localparam int unsigned TIDX_W = $clog2(TRACE_DEPTH);

    logic [XLEN+1:0]   trace_mem [TRACE_DEPTH];
    logic [TIDX_W-1:0] wr_ptr_q;
    logic [TIDX_W:0]   count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (apply) begin
            wr_ptr_q <= wr_ptr_q + TIDX_W'(1);
            if (count_q != (TIDX_W + 1)'(TRACE_DEPTH)) begin
                count_q <= count_q + (TIDX_W + 1)'(1);
            end
        end
    end

    // Storage is deliberately not reset; only the pointer and count are.
    always_ff @(posedge clk) begin
        if (apply) begin
            trace_mem[wr_ptr_q] <= {arb_src, arb_tgt};
        end
    end

    assign trace_entry = trace_mem[wr_ptr_q - TIDX_W'(1) - trace_idx];
    assign trace_count = count_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a behavioural next-PC model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = '0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;
    logic        id_redirect = 1'b0;
    logic [31:0] id_target = '0;
    logic        pc_ready = 1'b1;
    logic [31:0] pc;
    logic        pc_valid;
    logic        redirected;
    logic        misalign_err;
`ifdef PC_TRACE_EN
    logic [2:0]  trace_idx = '0;
    logic [33:0] trace_entry;
    logic [3:0]  trace_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .STEP         (4),
        .TRACE_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .trap_valid   (trap_valid),
        .trap_target  (trap_target),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .id_redirect  (id_redirect),
        .id_target    (id_target),
        .pc_ready     (pc_ready),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .redirected   (redirected),
        .misalign_err (misalign_err)
`ifdef PC_TRACE_EN
        ,
        .trace_idx    (trace_idx),
        .trace_entry  (trace_entry),
        .trace_count  (trace_count)
`endif
    );

    // Behavioural model: priorities as integers 3=trap, 2=ex, 1=id, 0=none.
    logic [31:0] m_pc;
    bit          m_valid, m_red, m_mis, m_booted;
    int          m_pend;
    logic [31:0] m_ptgt;

    function automatic logic [34:0] obs();
        return {pc, pc_valid, redirected, misalign_err};
    endfunction

    function automatic logic [34:0] expv();
        return {m_pc, m_valid, m_red, m_mis};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 0; m_red = 0; m_mis = 0;
        m_booted = 0; m_pend = 0; m_ptgt = '0;
    endtask

    task automatic model_edge();
        int          fsrc;
        logic [31:0] ftgt;
        m_red = 0;
        m_mis = 0;
        if (!m_booted) begin
            m_booted = 1;
            m_valid  = 1;
            return;
        end
        fsrc = 0;
        ftgt = '0;
        if (trap_valid)       begin fsrc = 3; ftgt = trap_target; end
        else if (ex_redirect) begin fsrc = 2; ftgt = ex_target;   end
        else if (id_redirect) begin fsrc = 1; ftgt = id_target;   end
        if (m_pend > fsrc) begin
            fsrc = m_pend;
            ftgt = m_ptgt;
        end
        if (fsrc == 0) begin
            if (!stall && pc_ready) m_pc = m_pc + 32'd4;
        end else if (fsrc == 3 || !stall) begin
            m_pc   = ftgt - (ftgt % 32'd4);
            m_mis  = (ftgt % 32'd4) != 0;
            m_red  = 1;
            m_pend = 0;
        end else begin
            m_pend = fsrc;
            m_ptgt = ftgt;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; trap_valid = 0; ex_redirect = 0; id_redirect = 0;
        trap_target = '0; ex_target = '0; id_target = '0; pc_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if (obs() !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs(), 35'h0);
        end
        reset = 1;
        #1;
        vectors++;
        if (pc_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_valid_low: got %b want 0", pc_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs() !== expv() || pc !== 32'(4 * i) || pc_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL boot_step%0d: got %h want %h pc %h", i, obs(), expv(), 32'(4 * i));
            end
        end
    endtask

    task automatic test_increment();
        while (m_pc != 32'h10) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL increment: got %h want %h", obs(), expv());
            end
        end
    endtask

    task automatic test_same_cycle();
        ex_redirect = 1; ex_target = 32'h200;
        id_redirect = 1; id_target = 32'h80;
        tick();
        idle();
        vectors++;
        if (obs() !== expv() || pc !== 32'h200 || redirected !== 1'b1) begin
            miscompares++;
            $display("FAIL ex_over_id: got %h want %h", obs(), expv());
        end
        tick();
        vectors++;
        if (obs() !== expv() || redirected !== 1'b0 || pc !== 32'h204) begin
            miscompares++;
            $display("FAIL redirect_pulse: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_stall_pending();
        logic [31:0] held;
        for (int pass = 0; pass < 2; pass++) begin
            held = m_pc;
            stall = 1;
            for (int c = 1; c <= 3; c++) begin
                id_redirect = (c == 1); id_target = 32'h80;
                ex_redirect = (pass == 0 && c == 2); ex_target = 32'h300;
                tick();
                vectors++;
                if (obs() !== expv() || pc !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold p%0d c%0d: got %h want %h", pass, c, obs(), expv());
                end
            end
            idle();
            tick();
            vectors++;
            if (obs() !== expv() || pc !== (pass == 0 ? 32'h300 : 32'h80) || redirected !== 1'b1) begin
                miscompares++;
                $display("FAIL pend_apply p%0d: got %h want %h", pass, obs(), expv());
            end
        end
    endtask

    task automatic test_trap_in_pend();
        stall = 1; id_redirect = 1; id_target = 32'h80;
        tick();
        id_redirect = 0; trap_valid = 1; trap_target = 32'h1000;
        tick();
        vectors++;
        if (obs() !== expv() || pc !== 32'h1000 || redirected !== 1'b1) begin
            miscompares++;
            $display("FAIL trap_in_pend: got %h want %h", obs(), expv());
        end
        trap_valid = 0;
        tick();
        idle();
        tick();
        vectors++;
        if (obs() !== expv() || pc !== 32'h1004 || redirected !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_clears_pend: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_misalign_wrap();
        ex_redirect = 1; ex_target = 32'h203;
        tick();
        idle();
        vectors++;
        if (obs() !== expv() || pc !== 32'h200 || misalign_err !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign: got %h want %h", obs(), expv());
        end
        tick();
        vectors++;
        if (obs() !== expv() || misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_pulse: got %h want %h", obs(), expv());
        end
        trap_valid = 1; trap_target = 32'hFFFF_FFFC;
        tick();
        idle();
        tick();
        vectors++;
        if (obs() !== expv() || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_ready_low();
        pc_ready = 0;
        tick();
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL ready_hold: got %h want %h", obs(), expv());
        end
        id_redirect = 1; id_target = 32'h440;
        tick();
        idle();
        vectors++;
        if (obs() !== expv() || pc !== 32'h440) begin
            miscompares++;
            $display("FAIL redirect_no_ready: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_reset_in_pend();
        stall = 1; id_redirect = 1; id_target = 32'h40;
        tick();
        idle();
        reset = 0;
        model_reset();
        #1;
        vectors++;
        if (obs() !== expv() || pc !== 32'h0 || pc_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", obs(), expv());
        end
        @(posedge clk);
        #1;
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs() !== expv() || redirected !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_drops_pend%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            trap_valid  = ($urandom_range(0, 19) == 0);
            ex_redirect = ($urandom_range(0, 6) == 0);
            id_redirect = ($urandom_range(0, 6) == 0);
            pc_ready    = ($urandom_range(0, 4) != 0);
            trap_target = $urandom();
            ex_target   = $urandom();
            id_target   = $urandom();
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random%0d: got %h want %h", i, obs(), expv());
            end
        end
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

`ifdef PC_TRACE_EN
    task automatic test_trace();
        for (int k = 1; k <= 10; k++) begin
            ex_redirect = 1; ex_target = 32'(k * 32'h100);
            tick();
        end
        idle();
        trace_idx = 3'd0;
        #1;
        vectors++;
        if (trace_count !== 4'd8 || trace_entry !== {2'b10, 32'hA00}) begin
            miscompares++;
            $display("FAIL trace_newest: got cnt %0d %h want 8 %h", trace_count, trace_entry, {2'b10, 32'hA00});
        end
        trace_idx = 3'd7;
        #1;
        vectors++;
        if (trace_entry !== {2'b10, 32'h300}) begin
            miscompares++;
            $display("FAIL trace_oldest: got %h want %h", trace_entry, {2'b10, 32'h300});
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_increment();
        test_same_cycle();
        test_stall_pending();
        test_trap_in_pend();
        test_misalign_wrap();
        test_ready_low();
        test_reset_in_pend();
        test_random();
`ifdef PC_TRACE_EN
        test_trace();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
